// File: rtl/exec_unit.sv
// exec_unit -- multi-cycle execute stage feeding the 8-bit register file.
//
// Accepts two operands plus a destination register on Start (when not Busy),
// computes an ALU / shift / multiply result, then drives the register-file
// write port (WriteEn/Waddr/DataOut) for exactly one cycle.
//
// Optional feature macro: EXEC_UNIT_MUL_EN
//   defined   : Op 110 is a W-cycle unsigned shift-add multiply
//   undefined : Op 110 is single-cycle with result 0, Carry 0
//
// Ports:
//   Clk, Reset        clock (rising edge), async active-low reset
//   Start, Op, InA,   request handshake, operation select, operands and
//   InB, Dest         destination register (all sampled on accept)
//   Busy              high in RUN and WB
//   Done, WriteEn     one-cycle pulse in WB
//   Waddr, DataOut    register-file write address/data (valid with WriteEn)
//   Zero, Carry       result flags, updated when leaving WB
module exec_unit #(
  parameter int W = 8,
  parameter int A = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [2:0]   Op,
  input  logic [W-1:0] InA,
  input  logic [W-1:0] InB,
  input  logic [A-1:0] Dest,
  output logic         Busy,
  output logic         Done,
  output logic         WriteEn,
  output logic [A-1:0] Waddr,
  output logic [W-1:0] DataOut,
  output logic         Zero,
  output logic         Carry
);
  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_XOR = 3'b011, OP_SHL = 3'b100, OP_SHR = 3'b101,
                         OP_MUL = 3'b110, OP_PASSB = 3'b111;

`ifdef EXEC_UNIT_MUL_EN
  // Counter must reach W for the multiply as well as 7 for shifts.
  localparam int CW = ($clog2(W+1) > 3) ? $clog2(W+1) : 3;
`else
  localparam int CW = 3;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB} state_t;

  state_t         state_q;
  logic [2:0]     op_q;
  logic [A-1:0]   dest_q;
  logic [W-1:0]   a_q;
  logic [CW-1:0]  cnt_q;
  logic           rc_q;      // carry of the result waiting in WB
  logic [W-1:0]   dout_q;
  logic [A-1:0]   waddr_q;
  logic           zero_q, carry_q;

  logic [W-1:0]   fast_res;
  logic           fast_c;
  logic           go_run;
  logic [W-1:0]   shl_nxt, shr_nxt;

`ifdef EXEC_UNIT_MUL_EN
  // {high, low}: low starts as the multiplier and is consumed LSB first
  // while the product shifts in from the top.
  logic [2*W-1:0] p_q;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] p_nxt;
  assign mul_sum = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, a_q} : '0);
  assign p_nxt   = {mul_sum, p_q[W-1:1]};
`endif

  assign shl_nxt = {a_q[W-2:0], 1'b0};
  assign shr_nxt = {1'b0, a_q[W-1:1]};

  // Result for ops that go straight to WB; a zero-distance shift passes A.
  always_comb begin
    fast_res = '0;
    fast_c   = 1'b0;
    case (Op)
      OP_ADD:         {fast_c, fast_res} = {1'b0, InA} + {1'b0, InB};
      OP_SUB:         begin fast_res = InA - InB; fast_c = (InA >= InB); end
      OP_AND:         fast_res = InA & InB;
      OP_XOR:         fast_res = InA ^ InB;
      OP_PASSB:       fast_res = InB;
      OP_SHL, OP_SHR: fast_res = InA;
      default:        fast_res = '0;
    endcase
  end

`ifdef EXEC_UNIT_MUL_EN
  assign go_run = ((Op == OP_SHL || Op == OP_SHR) && InB[2:0] != 3'd0) || (Op == OP_MUL);
`else
  assign go_run = (Op == OP_SHL || Op == OP_SHR) && InB[2:0] != 3'd0;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      dest_q  <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      rc_q    <= 1'b0;
      dout_q  <= '0;
      waddr_q <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
`ifdef EXEC_UNIT_MUL_EN
      p_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (Start) begin
          op_q   <= Op;
          dest_q <= Dest;
          a_q    <= InA;
          if (go_run) begin
            state_q <= S_RUN;
            cnt_q   <= CW'(InB[2:0]);
`ifdef EXEC_UNIT_MUL_EN
            if (Op == OP_MUL) cnt_q <= CW'(W);
            p_q <= {{W{1'b0}}, InB};
`endif
          end else begin
            state_q <= S_WB;
            dout_q  <= fast_res;
            rc_q    <= fast_c;
            waddr_q <= Dest;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - CW'(1);
          case (op_q)
            OP_SHL: begin a_q <= shl_nxt; rc_q <= a_q[W-1]; end
            OP_SHR: begin a_q <= shr_nxt; rc_q <= a_q[0];   end
`ifdef EXEC_UNIT_MUL_EN
            OP_MUL: p_q <= p_nxt;
`endif
            default: ;
          endcase
          if (cnt_q == CW'(1)) begin
            state_q <= S_WB;
            waddr_q <= dest_q;
            case (op_q)
              OP_SHL:  dout_q <= shl_nxt;
              OP_SHR:  dout_q <= shr_nxt;
`ifdef EXEC_UNIT_MUL_EN
              OP_MUL:  begin dout_q <= p_nxt[W-1:0]; rc_q <= |p_nxt[2*W-1:W]; end
`endif
              default: dout_q <= '0;
            endcase
          end
        end
        S_WB: begin
          state_q <= S_IDLE;
          zero_q  <= (dout_q == '0);
          carry_q <= rc_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Busy    = (state_q != S_IDLE);
  assign WriteEn = (state_q == S_WB);
  assign Done    = WriteEn;
  assign Waddr   = waddr_q;
  assign DataOut = dout_q;
  assign Zero    = zero_q;
  assign Carry   = carry_q;
endmodule
